// File: rtl/change_dispenser_if.sv
// Handshake bundle between the change dispenser and its controller/hopper.
interface change_dispenser_if;
    logic [4:0] change_in;
    logic       change_valid;
    logic       abort;
    logic       coin_ack;
    logic [2:0] coin_out;
    logic       coin_valid;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] remaining;
    logic [3:0] coins_paid;
    logic [1:0] state;

    // Controller/hopper side: issues requests and acks, observes status.
    modport master (
        output change_in, change_valid, abort, coin_ack,
        input  coin_out, coin_valid, busy, done, error, remaining, coins_paid, state
    );

    // Dispenser side.
    modport slave (
        input  change_in, change_valid, abort, coin_ack,
        output coin_out, coin_valid, busy, done, error, remaining, coins_paid, state
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out an amount using Rs10/5/2/1 coins,
// one coin per SELECT/PAY round trip with the hopper.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SELECT = 2'b01,
        PAY    = 2'b10,
        FINISH = 2'b11
    } state_t;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_RS1  = 3'b001;
    localparam logic [2:0] C_RS2  = 3'b010;
    localparam logic [2:0] C_RS5  = 3'b011;
    localparam logic [2:0] C_RS10 = 3'b100;

    // Last count value before the timeout fires on the following edge.
    localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

    state_t     r_state;
    logic [2:0] r_coin_out;
    logic       r_coin_valid;
    logic       r_busy;
    logic       r_done;
    logic       r_error;
    logic [4:0] r_remaining;
    logic [3:0] r_coins_paid;
    logic [3:0] r_tmo_cnt;

    logic [2:0] w_pick;
    logic [4:0] w_coin_val;
    logic [4:0] w_rem_next;

    // Greedy choice; the largest coin never exceeds remaining, so no underflow.
    always_comb begin
        w_pick = C_RS1;
        if (r_remaining >= 5'd10)     w_pick = C_RS10;
        else if (r_remaining >= 5'd5) w_pick = C_RS5;
        else if (r_remaining >= 5'd2) w_pick = C_RS2;
    end

    // Value of the coin currently presented to the hopper.
    always_comb begin
        case (r_coin_out)
            C_RS1:   w_coin_val = 5'd1;
            C_RS2:   w_coin_val = 5'd2;
            C_RS5:   w_coin_val = 5'd5;
            C_RS10:  w_coin_val = 5'd10;
            default: w_coin_val = 5'd0;
        endcase
    end

    assign w_rem_next = r_remaining - w_coin_val;

    // Control FSM; every output is a register, so the hopper sees no input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_coin_out   <= C_NONE;
            r_coin_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_remaining  <= 5'd0;
            r_coins_paid <= 4'd0;
            r_tmo_cnt    <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.change_valid) begin
                        if (bus.change_in != 5'd0) begin
                            r_remaining  <= bus.change_in;
                            r_coins_paid <= 4'd0;
                            r_error      <= 1'b0;
                            r_busy       <= 1'b1;
                            r_state      <= SELECT;
                        end else begin
                            // Nothing to pay: acknowledge with a bare done pulse.
                            r_done <= 1'b1;
                        end
                    end
                end
                SELECT: begin
                    if (bus.abort) begin
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_coin_out   <= w_pick;
                        r_coin_valid <= 1'b1;
                        r_tmo_cnt    <= 4'd0;
                        r_state      <= PAY;
                    end
                end
                PAY: begin
                    if (bus.coin_ack) begin
                        // An ack always counts, even if abort arrives with it.
                        r_remaining  <= w_rem_next;
                        r_coins_paid <= r_coins_paid + 4'd1;
                        r_coin_valid <= 1'b0;
                        r_coin_out   <= C_NONE;
                        if (w_rem_next == 5'd0 || bus.abort) begin
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_state <= SELECT;
                        end
                    end else if (bus.abort) begin
                        r_coin_valid <= 1'b0;
                        r_coin_out   <= C_NONE;
                        r_done       <= 1'b1;
                        r_state      <= FINISH;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_error      <= 1'b1;
                        r_coin_valid <= 1'b0;
                        r_coin_out   <= C_NONE;
                        r_done       <= 1'b1;
                        r_state      <= FINISH;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 4'd1;
                    end
                end
                FINISH: begin
                    // done was raised on entry, so it lasts exactly this cycle.
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.coin_out   = r_coin_out;
    assign bus.coin_valid = r_coin_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.remaining  = r_remaining;
    assign bus.coins_paid = r_coins_paid;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: scoreboard of expected coins popped on each ack.
module tb_change_dispenser;
    logic clk;
    logic rst;
    change_dispenser_if bus();

    change_dispenser #(.ACK_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [4:0] rem;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int d_dones, d_cycles, d_valid, d_after, d_unstable;
    logic [2:0] d_first;
    bit   d_ok;

    // Scoreboard: every accepted coin must match the head of the expected queue.
    always @(negedge clk) begin
        #1;
        if (rst && bus.coin_valid && bus.coin_ack) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_coin: got code %0d, want no coin", bus.coin_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.coin_out !== e.code || bus.remaining !== e.rem) begin
                    miscompares++;
                    $display("FAIL sb_coin: got code %0d rem %0d, want code %0d rem %0d",
                             bus.coin_out, bus.remaining, e.code, e.rem);
                end
            end
        end
    end

    task automatic push(input logic [2:0] code, input logic [4:0] rem);
        exp_t e;
        e.code = code;
        e.rem  = rem;
        q.push_back(e);
    endtask

    task automatic load(input logic [4:0] amt);
        @(negedge clk);
        bus.change_in    = amt;
        bus.change_valid = 1'b1;
        @(negedge clk);
        bus.change_valid = 1'b0;
    endtask

    // Plays the hopper: acks after 'delay' waiting cycles (never if negative),
    // raises abort with ack number 'abort_coin', stops once back in IDLE after done.
    task automatic drive(input int delay, input int abort_coin);
        int wait_c = 0;
        int idx = 0;
        bit prev_hold = 0;
        bit aborted = 0;
        logic [2:0] prev_code = 3'b000;
        d_dones = 0; d_cycles = 0; d_valid = 0; d_after = 0; d_unstable = 0;
        d_first = 3'b000; d_ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            d_cycles++;
            bus.coin_ack = 1'b0;
            bus.abort    = 1'b0;
            if (bus.done) d_dones++;
            if (bus.state == 2'b00 && d_dones > 0) begin
                d_ok = 1;
                break;
            end
            if (bus.coin_valid) begin
                d_valid++;
                if (aborted) d_after++;
                if (d_valid == 1) d_first = bus.coin_out;
                if (prev_hold && bus.coin_out !== prev_code) d_unstable++;
                if (delay >= 0 && wait_c >= delay) begin
                    bus.coin_ack = 1'b1;
                    if (idx == abort_coin) begin
                        bus.abort = 1'b1;
                        aborted = 1;
                    end
                    idx++;
                    wait_c = 0;
                    prev_hold = 0;
                end else begin
                    wait_c++;
                    prev_hold = 1;
                    prev_code = bus.coin_out;
                end
            end else begin
                prev_hold = 0;
            end
        end
        bus.coin_ack = 1'b0;
        bus.abort    = 1'b0;
        vectors++;
        if (d_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL drive_timeout: transaction never returned to IDLE with done");
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.change_in = 5'd0; bus.change_valid = 1'b0; bus.abort = 1'b0; bus.coin_ack = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.state, bus.coin_out, bus.coin_valid, bus.busy, bus.done, bus.error,
             bus.remaining, bus.coins_paid} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state: got state %0d valid %0b busy %0b rem %0d, want all zero",
                     bus.state, bus.coin_valid, bus.busy, bus.remaining);
        end
        rst = 1'b1;
    endtask

    task automatic test_zero_load;
        load(5'd0);
        vectors++;
        if ({bus.done, bus.state, bus.remaining, bus.busy} !== {1'b1, 2'b00, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL zero_load_pulse: got done %0b state %0d rem %0d, want done 1 IDLE rem 0",
                     bus.done, bus.state, bus.remaining);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_load_width: got done %0b, want 0", bus.done);
        end
    endtask

    task automatic test_single_coin;
        push(3'b011, 5'd5);
        load(5'd5);
        drive(0, -1);
        vectors++;
        if ({bus.remaining, bus.coins_paid} !== {5'd0, 4'd1} || d_dones != 1 || d_cycles != 3) begin
            miscompares++;
            $display("FAIL single_coin: got rem %0d paid %0d dones %0d cycles %0d, want 0 1 1 3",
                     bus.remaining, bus.coins_paid, d_dones, d_cycles);
        end
    endtask

    task automatic test_greedy_18;
        push(3'b100, 5'd18); push(3'b011, 5'd8); push(3'b010, 5'd3); push(3'b001, 5'd1);
        load(5'd18);
        drive(0, -1);
        vectors++;
        if ({bus.remaining, bus.coins_paid} !== {5'd0, 4'd4} || d_cycles != 9 || q.size() != 0) begin
            miscompares++;
            $display("FAIL greedy_18: got rem %0d paid %0d cycles %0d left %0d, want 0 4 9 0",
                     bus.remaining, bus.coins_paid, d_cycles, q.size());
        end
    endtask

    task automatic test_slow_ack_29;
        push(3'b100, 5'd29); push(3'b100, 5'd19); push(3'b011, 5'd9);
        push(3'b010, 5'd4);  push(3'b010, 5'd2);
        load(5'd29);
        drive(3, -1);
        vectors++;
        if ({bus.remaining, bus.coins_paid} !== {5'd0, 4'd5} || q.size() != 0 || d_dones != 1) begin
            miscompares++;
            $display("FAIL slow_ack_29: got rem %0d paid %0d left %0d dones %0d, want 0 5 0 1",
                     bus.remaining, bus.coins_paid, q.size(), d_dones);
        end
        vectors++;
        if (d_unstable != 0 || d_valid != 20) begin
            miscompares++;
            $display("FAIL slow_ack_hold: got unstable %0d valid cycles %0d, want 0 20",
                     d_unstable, d_valid);
        end
    endtask

    task automatic test_timeout;
        load(5'd8);
        drive(-1, -1);
        vectors++;
        if (d_first !== 3'b011 || d_valid != 8) begin
            miscompares++;
            $display("FAIL timeout_hold: got code %0d for %0d cycles, want 3 for 8", d_first, d_valid);
        end
        vectors++;
        if ({bus.error, bus.remaining, bus.coins_paid, bus.state} !== {1'b1, 5'd8, 4'd0, 2'b00}
            || d_dones != 1) begin
            miscompares++;
            $display("FAIL timeout_end: got err %0b rem %0d paid %0d state %0d dones %0d, want 1 8 0 0 1",
                     bus.error, bus.remaining, bus.coins_paid, bus.state, d_dones);
        end
    endtask

    task automatic test_abort_17;
        push(3'b100, 5'd17);
        load(5'd17);
        vectors++;
        if (bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL load_clears_error: got err %0b, want 0", bus.error);
        end
        drive(0, 0);
        vectors++;
        if ({bus.remaining, bus.coins_paid} !== {5'd7, 4'd1} || d_after != 0 || d_dones != 1) begin
            miscompares++;
            $display("FAIL abort_17: got rem %0d paid %0d extra valid %0d dones %0d, want 7 1 0 1",
                     bus.remaining, bus.coins_paid, d_after, d_dones);
        end
    endtask

    task automatic test_reset_mid_pay;
        bit bad = 0;
        push(3'b100, 5'd31);
        load(5'd31);
        @(negedge clk); bus.coin_ack = 1'b1;   // first PAY, ack Rs10
        @(negedge clk); bus.coin_ack = 1'b0;   // SELECT
        @(negedge clk);                        // second PAY
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({bus.state, bus.coin_out, bus.coin_valid, bus.busy, bus.done, bus.error,
             bus.remaining, bus.coins_paid} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset: got state %0d valid %0b rem %0d paid %0d, want all zero",
                     bus.state, bus.coin_valid, bus.remaining, bus.coins_paid);
        end
        repeat (2) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.state !== 2'b00 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad || q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_abandon: got bad %0b left %0d, want 0 0", bad, q.size());
        end
    endtask

    task automatic test_release_load;
        bus.abort = 1'b1;                      // abort in IDLE is a no-op
        @(negedge clk);
        vectors++;
        if ({bus.state, bus.done} !== {2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_abort: got state %0d done %0b, want 0 0", bus.state, bus.done);
        end
        bus.abort = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.change_in = 5'd3;
        bus.change_valid = 1'b1;
        @(negedge clk);
        bus.change_valid = 1'b0;
        vectors++;
        if ({bus.state, bus.remaining} !== {2'b01, 5'd3}) begin
            miscompares++;
            $display("FAIL first_load: got state %0d rem %0d, want 1 3", bus.state, bus.remaining);
        end
        bus.abort = 1'b1;                      // abort while in SELECT
        @(negedge clk);
        bus.abort = 1'b0;
        vectors++;
        if ({bus.state, bus.done, bus.coin_valid, bus.remaining} !== {2'b11, 1'b1, 1'b0, 5'd3}) begin
            miscompares++;
            $display("FAIL select_abort: got state %0d done %0b valid %0b rem %0d, want 3 1 0 3",
                     bus.state, bus.done, bus.coin_valid, bus.remaining);
        end
        @(negedge clk);
        vectors++;
        if ({bus.state, bus.done, bus.busy} !== {2'b00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL finish_to_idle: got state %0d done %0b busy %0b, want 0 0 0",
                     bus.state, bus.done, bus.busy);
        end
    endtask

    initial begin
        test_reset;
        test_zero_load;
        test_single_coin;
        test_greedy_18;
        test_slow_ack_29;
        test_timeout;
        test_abort_17;
        test_reset_mid_pay;
        test_release_load;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 8: maximum PAY cycles without coin_ack before error; legal range 1-15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port change_in, input, 5 bits: rupee amount to pay out, 0-31.
REQ-005 SHALL have port change_valid, input, 1 bit: load request for change_in.
REQ-006 SHALL have port abort, input, 1 bit: stop the payout after any coin in flight.
REQ-007 SHALL have port coin_ack, input, 1 bit: hopper accepted the presented coin.
REQ-008 SHALL have port coin_out, output, 3 bits: coin code; 000 none, 001 Rs1, 010 Rs2, 011 Rs5, 100 Rs10.
REQ-009 SHALL have port coin_valid, output, 1 bit: coin_out is presented to the hopper.
REQ-010 SHALL have port busy, output, 1 bit: a transaction is in progress (state != IDLE).
REQ-011 SHALL have port done, output, 1 bit: one-cycle end-of-transaction pulse.
REQ-012 SHALL have port error, output, 1 bit: sticky ack-timeout flag.
REQ-013 SHALL have port remaining, output, 5 bits: amount still unpaid.
REQ-014 SHALL have port coins_paid, output, 4 bits: coins acknowledged in the current transaction.
REQ-015 SHALL have port state, output, 2 bits: IDLE=00, SELECT=01, PAY=10, FINISH=11.

Function
REQ-016 SHALL register all outputs; coin_out and coin_valid SHALL NOT have a combinational path from any input.
REQ-017 In IDLE, change_valid=1 with change_in!=0 SHALL do all of the following: load remaining=change_in, clear coins_paid, clear error, and move to SELECT.
REQ-018 In IDLE, change_valid=1 with change_in=0 SHALL pulse done for 1 cycle, leave remaining=0, and stay in IDLE.
REQ-019 SHALL ignore change_valid whenever state != IDLE.
REQ-020 SELECT SHALL last 1 cycle and choose the greedy coin: Rs10 if remaining>=10, else Rs5 if >=5, else Rs2 if >=2, else Rs1.
REQ-021 SELECT SHALL drive the chosen code on coin_out with coin_valid=1 from the next cycle, and then move to PAY.
REQ-022 In PAY, coin_out and coin_valid SHALL hold stable until coin_ack is sampled high.
REQ-023 In PAY, on coin_ack SHALL do all of the following: subtract the coin value from remaining, increment coins_paid, set coin_valid=0 and coin_out=000 next cycle.
REQ-024 After the coin_ack update of REQ-023, SHALL go to FINISH if the new remaining is 0, else to SELECT.
REQ-025 SHALL count consecutive PAY cycles without coin_ack; on reaching ACK_TIMEOUT SHALL set error=1, drop coin_valid, keep remaining unchanged, and go to FINISH.
REQ-026 abort in SELECT, or in PAY without coin_ack, SHALL go to FINISH next cycle, drop coin_valid, and keep remaining.
REQ-027 abort together with coin_ack in PAY SHALL count the coin per REQ-023, then go to FINISH.
REQ-028 In IDLE, abort SHALL have no effect.
REQ-029 FINISH SHALL assert done for exactly 1 cycle and then return to IDLE.
REQ-030 remaining and coins_paid SHALL hold their values in IDLE until the next accepted load.
REQ-031 remaining SHALL never underflow; the greedy choice guarantees coin value <= remaining.
REQ-032 Worst-case coin count is 5 (29 = 10+10+5+2+2).
REQ-033 Latency with immediate ack SHALL be 2 cycles per coin plus 1 FINISH cycle after load.

Reset
REQ-034 rst=0 SHALL immediately force the following outputs and hold them while low: state=IDLE, coin_out=000, coin_valid=0, busy=0, done=0, error=0, remaining=0, coins_paid=0, timeout counter=0.
REQ-035 Reset asserted mid-PAY SHALL abandon the transaction with no done pulse.
REQ-036 The first load after reset release SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-037 Load 5, ack the cycle coin_valid rises -> one coin 011, remaining 0, coins_paid=1, done 1 cycle.
REQ-038 Load 18, immediate acks -> coins 100,011,010,001; remaining 8,3,1,0; coins_paid=4.
REQ-039 Load 29, ack delayed 3 cycles per coin -> coins 100,100,011,010,010; coin_out stable while waiting; coins_paid=5.
REQ-040 Load 8, coin_ack never asserted, ACK_TIMEOUT=8 -> coin 011 held 8 cycles, then error=1, remaining=8, done, IDLE.
REQ-041 Load 17, abort with first coin's ack -> remaining=7, coins_paid=1, no further coin_valid, done.
REQ-042 Load 31, rst low during second PAY -> all outputs 0 asynchronously; change_valid=0 after release keeps IDLE.
